// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder
// and anything that models its result.
package adder_pkg;

  localparam int ADD_WIDTH = 4;

  // {carry, sum} result of one addition
  typedef logic [ADD_WIDTH:0] add_result_t;

endpackage : adder_pkg

// File: rtl/half_add.sv
// Single-bit half adder: the only cell in which the adder's XOR/AND
// logic lives.
module half_add (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule : half_add

// File: rtl/full_add_4bit.sv
// Registered ripple-carry adder. Each bit is two half adders plus an OR
// of their carries; the {carry, sum} result is captured every clock.
module full_add_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] s_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH:0]   c_s;
  add_result_t      result_s;
  add_result_t      result_r;

  assign c_s[0] = i_cin;

  // Carry ripples bit 0 to bit WIDTH-1 with no lookahead.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    half_add u_ha_ab (
      .i_a     (i_a[k]),
      .i_b     (i_b[k]),
      .o_sum   (p_s[k]),
      .o_carry (g_s[k])
    );

    half_add u_ha_pc (
      .i_a     (p_s[k]),
      .i_b     (c_s[k]),
      .o_sum   (s_s[k]),
      .o_carry (t_s[k])
    );

    assign c_s[k+1] = g_s[k] | t_s[k];
  end : g_bit

  assign result_s = {c_s[WIDTH], s_s};

  // Output register; reset wins over the result arriving at the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_r <= {(ADD_WIDTH + 1){1'b0}};
    end else begin
      result_r <= result_s;
    end
  end

  assign o_sum   = result_r[WIDTH-1:0];
  assign o_carry = result_r[WIDTH];

endmodule : full_add_4bit

// File: tb/tb_full_add_4bit.sv
// Directed and random bench for full_add_4bit against a plain-arithmetic
// reference model.
module tb_full_add_4bit;
  import adder_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       carry;

  int checks;
  int errors;

  add_result_t prev_exp;
  logic        have_prev;

  full_add_4bit dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_sum   (sum),
    .o_carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic add_result_t model(input logic [3:0] ma, input logic [3:0] mb,
                                        input logic mc, input logic mrst);
    int total;
    total = int'(ma) + int'(mb) + int'(mc);
    if (mrst) return add_result_t'(0);
    return add_result_t'(total);
  endfunction

  // Drive one vector at the falling edge, confirm the outputs still hold the
  // previous result, then confirm the new result one edge later.
  task automatic cycle(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic vrst, input string tag);
    add_result_t exp;
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    rst = vrst;
    exp = model(va, vb, vc, vrst);
    #1;
    if (have_prev) begin
      checks++;
      assert ({carry, sum} === prev_exp)
      else begin
        errors++;
        $error("FAIL %s_hold observed=%b expected=%b", tag, {carry, sum}, prev_exp);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert ({carry, sum} === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (a=%0d b=%0d cin=%0d rst=%0d)",
             tag, {carry, sum}, exp, va, vb, vc, vrst);
    end
    prev_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    have_prev = 1'b0;
    prev_exp  = '0;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;

    cycle(4'hF, 4'hF, 1'b1, 1'b1, "reset_1");
    cycle(4'hF, 4'hF, 1'b1, 1'b1, "reset_2");

    cycle(4'd0,  4'd0,  1'b0, 1'b0, "zero");
    cycle(4'd5,  4'd10, 1'b0, 1'b0, "five_ten");

    cycle(4'd15, 4'd0,  1'b1, 1'b0, "ripple_f0c");
    cycle(4'd15, 4'd15, 1'b1, 1'b0, "ripple_ffc");
    cycle(4'd8,  4'd8,  1'b0, 1'b0, "ripple_88");

    cycle(4'd3,  4'd4,  1'b1, 1'b0, "b2b_341");
    cycle(4'd7,  4'd9,  1'b0, 1'b0, "b2b_790");
    cycle(4'd12, 4'd6,  1'b1, 1'b0, "b2b_c61");

    cycle(4'd9,  4'd9,  1'b0, 1'b1, "midreset_99");
    cycle(4'd9,  4'd9,  1'b0, 1'b1, "midreset_hold");
    cycle(4'd1,  4'd2,  1'b0, 1'b0, "after_release");
    cycle(4'd9,  4'd9,  1'b0, 1'b0, "nine_nine");

    for (int i = 0; i < 250; i++) begin
      cycle(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
            1'($urandom_range(1, 0)), 1'b0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_full_add_4bit
